// File: rtl/dpc_pkg.sv
// Shared constants and helpers for the dead-pixel-correction path.
package dpc_pkg;

    localparam int unsigned DPC_WIDTH      = 8;
    localparam int unsigned DPC_IMG_WIDTH  = 640;
    localparam int unsigned DPC_IMG_HEIGHT = 512;

    // Column counter width for a line of w pixels (at least 1 bit).
    function automatic int unsigned dpc_cw(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Row counter width for a frame of h lines (at least 1 bit).
    function automatic int unsigned dpc_rw(input int unsigned h);
        return (h > 1) ? $clog2(h) : 1;
    endfunction

    localparam int unsigned DPC_CW = dpc_cw(DPC_IMG_WIDTH);
    localparam int unsigned DPC_RW = dpc_rw(DPC_IMG_HEIGHT);

    // Vertical replication mode, chosen by the row of the incoming pixel.
    typedef enum logic [1:0] {
        SEL_ROW0 = 2'd0,
        SEL_ROW1 = 2'd1,
        SEL_ROWN = 2'd2
    } row_sel_e;

endpackage

// File: rtl/dpc_line_mem.sv
// Simple-dual-port line RAM: synchronous read, read-before-write, no reset.
module dpc_line_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 640,
    parameter int unsigned AW    = 10
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read returns the pre-write contents when both ports hit the same address.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/dpc_line_buffer.sv
// Two-line row buffer feeding the 3x3 window: emits current, row-1 and row-2
// pixels of the same column, with edge replication on the top two rows.
module dpc_line_buffer
    import dpc_pkg::*;
#(
    parameter int unsigned WIDTH      = DPC_WIDTH,
    parameter int unsigned IMG_WIDTH  = DPC_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = DPC_IMG_HEIGHT,
    parameter int unsigned CW         = dpc_cw(IMG_WIDTH),
    parameter int unsigned RW         = dpc_rw(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] w1_out,
    output logic [WIDTH-1:0] w2_out,
    output logic [WIDTH-1:0] w3_out,
    output logic [CW-1:0]    out_col,
    output logic [RW-1:0]    out_row,
    output logic             out_eof
);

    // Position of the next expected pixel.
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;

    // Position of the pixel on the input this cycle, after sof override.
    logic             sof_take;
    logic [CW-1:0]    pix_col;
    logic [RW-1:0]    pix_row;
    logic             last_col;
    logic             last_row;
    row_sel_e         pix_sel;

    // Stage aligned with the line-memory read data.
    logic             v1_q;
    logic [WIDTH-1:0] data1_q;
    logic [CW-1:0]    col1_q;
    logic [RW-1:0]    row1_q;
    row_sel_e         sel1_q;
    logic             eof1_q;

    logic [WIDTH-1:0] a_data;
    logic [WIDTH-1:0] b_data;
    logic [WIDTH-1:0] w2_c;
    logic [WIDTH-1:0] w3_c;

    // Resolve the pixel position and the next counter values.
    always_comb begin
        sof_take = in_valid & in_sof;
        pix_col  = col_q;
        pix_row  = row_q;
        if (sof_take) begin
            pix_col = '0;
            pix_row = '0;
        end
        last_col = (pix_col == CW'(IMG_WIDTH - 1));
        last_row = (pix_row == RW'(IMG_HEIGHT - 1));

        col_d = col_q;
        row_d = row_q;
        if (in_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : pix_row + RW'(1);
            end else begin
                col_d = pix_col + CW'(1);
                row_d = pix_row;
            end
        end

        pix_sel = SEL_ROWN;
        if (pix_row == '0) begin
            pix_sel = SEL_ROW0;
        end else if (pix_row == RW'(1)) begin
            pix_sel = SEL_ROW1;
        end
    end

    // Column/row counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Capture the accepted pixel while the line memories are being read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            data1_q <= '0;
            col1_q  <= '0;
            row1_q  <= '0;
            sel1_q  <= SEL_ROW0;
            eof1_q  <= 1'b0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                data1_q <= in_data;
                col1_q  <= pix_col;
                row1_q  <= pix_row;
                sel1_q  <= pix_sel;
                eof1_q  <= last_col & last_row;
            end
        end
    end

    // lineA holds row-1: written with the incoming pixel at read time.
    dpc_line_mem #(
        .WIDTH (WIDTH),
        .DEPTH (IMG_WIDTH),
        .AW    (CW)
    ) u_line_a (
        .clk     (clk),
        .rd_en   (in_valid),
        .rd_addr (pix_col),
        .rd_data (a_data),
        .wr_en   (in_valid),
        .wr_addr (pix_col),
        .wr_data (in_data)
    );

    // lineB holds row-2: takes the old lineA word one cycle later, once it is read out.
    dpc_line_mem #(
        .WIDTH (WIDTH),
        .DEPTH (IMG_WIDTH),
        .AW    (CW)
    ) u_line_b (
        .clk     (clk),
        .rd_en   (in_valid),
        .rd_addr (pix_col),
        .rd_data (b_data),
        .wr_en   (v1_q),
        .wr_addr (col1_q),
        .wr_data (a_data)
    );

    // Top-edge replication mux.
    always_comb begin
        w2_c = a_data;
        w3_c = b_data;
        case (sel1_q)
            SEL_ROW0: begin
                w2_c = data1_q;
                w3_c = data1_q;
            end
            SEL_ROW1: begin
                w2_c = a_data;
                w3_c = a_data;
            end
            default: begin
                w2_c = a_data;
                w3_c = b_data;
            end
        endcase
    end

    // Output registers; data and position hold across input gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            w1_out    <= '0;
            w2_out    <= '0;
            w3_out    <= '0;
            out_col   <= '0;
            out_row   <= '0;
        end else begin
            out_valid <= v1_q;
            out_eof   <= v1_q & eof1_q;
            if (v1_q) begin
                w1_out  <= data1_q;
                w2_out  <= w2_c;
                w3_out  <= w3_c;
                out_col <= col1_q;
                out_row <= row1_q;
            end
        end
    end

endmodule

// File: tb/tb_dpc_line_buffer.sv
// Scoreboard bench for dpc_line_buffer on a 4x4 image.
module tb_dpc_line_buffer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned IW    = 4;
    localparam int unsigned IH    = 4;
    localparam int unsigned CW    = 2;
    localparam int unsigned RW    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic [WIDTH-1:0] w1_out, w2_out, w3_out;
    logic [CW-1:0]    out_col;
    logic [RW-1:0]    out_row;
    logic             out_eof;

    dpc_line_buffer #(
        .WIDTH      (WIDTH),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH),
        .CW         (CW),
        .RW         (RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .w1_out    (w1_out),
        .w2_out    (w2_out),
        .w3_out    (w3_out),
        .out_col   (out_col),
        .out_row   (out_row),
        .out_eof   (out_eof)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] w1, w2, w3;
        logic [CW-1:0]    col;
        logic [RW-1:0]    row;
        logic             eof;
        int               due;
        string            name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    // Behavioural reference: two line arrays and a position counter.
    logic [WIDTH-1:0] m_a [IW];
    logic [WIDTH-1:0] m_b [IW];
    int               m_col = 0;
    int               m_row = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input logic [WIDTH-1:0] d, input logic sof, input bit hand,
                            input logic [WIDTH-1:0] h1, input logic [WIDTH-1:0] h2,
                            input logic [WIDTH-1:0] h3, input int hc, input int hr,
                            input logic he, input string nm);
        exp_t e;
        int c, r;
        logic [WIDTH-1:0] a, b;
        c = sof ? 0 : m_col;
        r = sof ? 0 : m_row;
        a = m_a[c];
        b = m_b[c];
        m_a[c] = d;
        m_b[c] = a;
        e.w1  = d;
        e.w2  = (r == 0) ? d : a;
        e.w3  = (r == 0) ? d : ((r == 1) ? a : b);
        e.col = CW'(c);
        e.row = RW'(r);
        e.eof = (c == IW - 1) && (r == IH - 1);
        if (c == IW - 1) begin
            m_col = 0;
            m_row = (r == IH - 1) ? 0 : r + 1;
        end else begin
            m_col = c + 1;
            m_row = r;
        end
        if (hand) begin
            e.w1  = h1;
            e.w2  = h2;
            e.w3  = h3;
            e.col = CW'(hc);
            e.row = RW'(hr);
            e.eof = he;
        end
        e.due  = cyc + 2;
        e.name = nm;
        q.push_back(e);
    endtask

    // Drive one pixel (model-predicted expectation).
    task automatic send(input logic [WIDTH-1:0] d, input logic sof);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        push_exp(d, sof, 1'b0, '0, '0, '0, 0, 0, 1'b0, $sformatf("pix_%02h", d));
    endtask

    // Drive one pixel with a hand-computed expectation.
    task automatic send_h(input logic [WIDTH-1:0] d, input logic sof,
                          input logic [WIDTH-1:0] h1, input logic [WIDTH-1:0] h2,
                          input logic [WIDTH-1:0] h3, input int hc, input int hr,
                          input logic he, input string nm);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        push_exp(d, sof, 1'b1, h1, h2, h3, hc, hr, he, nm);
    endtask

    task automatic gap();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b1;   // sof without valid must be ignored
        in_data  = 8'hEE;
    endtask

    task automatic drain();
        int k;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        k = 0;
        while (q.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d outputs still pending, required 0", q.size());
            q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        m_col = 0;
        m_row = 0;
    endtask

    // Monitor: compares outputs on the falling edge.
    logic [WIDTH-1:0] h_w1, h_w2, h_w3;
    logic [CW-1:0]    h_col;
    logic [RW-1:0]    h_row;
    bit               hold_ok = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                n_chk++;
                if (out_valid !== 1'b0 || out_eof !== 1'b0 || w1_out !== '0 || w2_out !== '0 ||
                    w3_out !== '0 || out_col !== '0 || out_row !== '0) begin
                    n_fail++;
                    $display("FAIL reset_zero: got v=%b eof=%b w=%h/%h/%h col=%0d row=%0d, required all 0",
                             out_valid, out_eof, w1_out, w2_out, w3_out, out_col, out_row);
                end
                h_w1 = '0; h_w2 = '0; h_w3 = '0; h_col = '0; h_row = '0;
                hold_ok = 1'b1;
            end else if (out_valid === 1'b1) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got w=%h/%h/%h col=%0d row=%0d, required no output",
                             w1_out, w2_out, w3_out, out_col, out_row);
                    h_w1 = w1_out; h_w2 = w2_out; h_w3 = w3_out; h_col = out_col; h_row = out_row;
                end else begin
                    e = q.pop_front();
                    if (cyc != e.due || w1_out !== e.w1 || w2_out !== e.w2 || w3_out !== e.w3 ||
                        out_col !== e.col || out_row !== e.row || out_eof !== e.eof) begin
                        n_fail++;
                        $display("FAIL %s: got cyc=%0d w=%h/%h/%h col=%0d row=%0d eof=%b, required cyc=%0d w=%h/%h/%h col=%0d row=%0d eof=%b",
                                 e.name, cyc, w1_out, w2_out, w3_out, out_col, out_row, out_eof,
                                 e.due, e.w1, e.w2, e.w3, e.col, e.row, e.eof);
                    end
                    h_w1 = e.w1; h_w2 = e.w2; h_w3 = e.w3; h_col = e.col; h_row = e.row;
                end
                hold_ok = 1'b1;
            end else begin
                if (q.size() != 0 && cyc >= q[0].due) begin
                    n_chk++;
                    n_fail++;
                    e = q.pop_front();
                    $display("FAIL %s_missing: got out_valid=%b at cyc=%0d, required 1", e.name, out_valid, cyc);
                end
                if (hold_ok) begin
                    n_chk++;
                    if (out_eof !== 1'b0 || w1_out !== h_w1 || w2_out !== h_w2 || w3_out !== h_w3 ||
                        out_col !== h_col || out_row !== h_row) begin
                        n_fail++;
                        $display("FAIL gap_hold: got eof=%b w=%h/%h/%h col=%0d row=%0d, required eof=0 w=%h/%h/%h col=%0d row=%0d",
                                 out_eof, w1_out, w2_out, w3_out, out_col, out_row,
                                 h_w1, h_w2, h_w3, h_col, h_row);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Continuous 4x4 frame, pixel = row*16 + col.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                logic [7:0] d;
                d = 8'(r * 16 + c);
                if (r == 0 && c == 3)
                    send_h(d, 1'b0, 8'h03, 8'h03, 8'h03, 3, 0, 1'b0, "r0c3_replicate");
                else if (r == 1 && c == 2)
                    send_h(d, 1'b0, 8'h12, 8'h02, 8'h02, 2, 1, 1'b0, "r1c2_replicate");
                else if (r == 2 && c == 1)
                    send_h(d, 1'b0, 8'h21, 8'h11, 8'h01, 1, 2, 1'b0, "r2c1_window");
                else if (r == 3 && c == 3)
                    send_h(d, 1'b0, 8'h33, 8'h23, 8'h13, 3, 3, 1'b1, "last_pixel_eof");
                else
                    send(d, (r == 0 && c == 0));
            end
        end

        // Next frame without sof, with 1010 valid toggling.
        send_h(8'h40, 1'b0, 8'h40, 8'h40, 8'h40, 0, 0, 1'b0, "wrap_to_origin");
        gap();
        send(8'h41, 1'b0); gap();
        send(8'h42, 1'b0); gap();
        send(8'h43, 1'b0); gap();
        send(8'h50, 1'b0); gap();
        send_h(8'h51, 1'b0, 8'h51, 8'h41, 8'h41, 1, 1, 1'b0, "toggle_r1c1");
        gap();

        // Mid-line sof at row 1, col 2.
        send_h(8'h99, 1'b1, 8'h99, 8'h99, 8'h99, 0, 0, 1'b0, "mid_sof");
        send_h(8'h9A, 1'b0, 8'h9A, 8'h9A, 8'h9A, 1, 0, 1'b0, "after_sof");
        send(8'h9B, 1'b0);
        send(8'h9C, 1'b0);
        send_h(8'hA0, 1'b0, 8'hA0, 8'h99, 8'h99, 0, 1, 1'b0, "sof_row1");
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        send_h(8'hB0, 1'b0, 8'hB0, 8'hA0, 8'h99, 0, 2, 1'b0, "sof_row2");
        send(8'hB1, 1'b0);
        drain();

        // Reset mid-row 2, then a frame started without sof.
        do_reset();
        send_h(8'hC0, 1'b0, 8'hC0, 8'hC0, 8'hC0, 0, 0, 1'b0, "post_reset_r0");
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        send_h(8'hD0, 1'b0, 8'hD0, 8'hC0, 8'hC0, 0, 1, 1'b0, "post_reset_r1");
        send(8'hD1, 1'b0);
        send(8'hD2, 1'b0);
        send(8'hD3, 1'b0);
        send_h(8'hE0, 1'b0, 8'hE0, 8'hD0, 8'hC0, 0, 2, 1'b0, "post_reset_r2");
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        send(8'hE3, 1'b0);
        send(8'hF0, 1'b0);
        send(8'hF1, 1'b0);
        send(8'hF2, 1'b0);
        send_h(8'hF3, 1'b0, 8'hF3, 8'hE3, 8'hD3, 3, 3, 1'b1, "post_reset_eof");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
